wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Writeback stage plus register file; the consumer of the EX/WB pipeline register outputs.
//  - Selects the writeback value from the data-memory result, the ALU result or the saved PC+1 (svpc).
//  - Commits that value to a 64 x DATA_W register file on the rising clock edge.
//  - Serves two combinational read ports to the decode stage, with write-through bypass.
//  - Keeps a free-running count of committed writes.
// PARAMETERS
//  DATA_W     32  width of a register and of every data path
//  ADDR_W      6  register address width; depth is 2**ADDR_W (64)
//  ZERO_REG    0  1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary
//  CNT_W      32  width of wrCount
// PORTS
//  clk          in   1        the single clock; all state changes on its rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  memToReg     in   1        1: writeback value is dataMem; 0: writeback value is ALU
//  dataMem      in   DATA_W   data-memory read result from EX/WB
//  ALU          in   DATA_W   ALU result from EX/WB
//  regWrt       in   1        write enable for this cycle
//  rd           in   ADDR_W   destination register
//  adder        in   DATA_W   PC+1 value from EX/WB
//  svpc         in   1        1: writeback value is adder; overrides memToReg
//  rs           in   ADDR_W   read port A address
//  rt           in   ADDR_W   read port B address
//  rsData       out  DATA_W   read port A data
//  rtData       out  DATA_W   read port B data
//  wbData       out  DATA_W   selected writeback value (combinational)
//  wrCount      out  CNT_W    number of committed writes, wraps modulo 2**CNT_W
// BEHAVIOUR
//  - Mux, combinational: wbData = svpc ? adder : (memToReg ? dataMem : ALU).
//    Priority: svpc > memToReg.
//  - Write, on posedge clk with rst_n=1 and regWrt=1:
//    - regs[rd] <= wbData.
//    - wrCount <= wrCount+1; it wraps from all-ones to 0 with no flag.
//    - Exception: with ZERO_REG=1 and rd=0, the register is not written but wrCount still increments.
//  - regWrt=0: no register changes and wrCount holds. The other inputs are don't-care.
//  - Read, combinational:
//    - rsData = bypass ? wbData : regs[rs], where bypass = regWrt && rd==rs && !(ZERO_REG && rs==0).
//    - rtData follows the same rule using rt.
//  - Bypass means a read in the same cycle as a write to that address returns the new value,
//    with zero-cycle write-to-read latency.
//  - rs==rt is legal: both ports return identical data.
//  - With ZERO_REG=1, a read of address 0 always returns 0, bypass included.
//  - Reset, asynchronous, whenever rst_n=0:
//    - All 64 registers clear to 0 and wrCount clears to 0.
//    - rsData and rtData therefore read 0, except when a bypass is active.
//    - wbData stays purely combinational and is not reset.
//  - Reset asserted in the same cycle as a write: the write is discarded and the register stays 0.
//  - First edge after rst_n deasserts: writes behave normally. No warm-up cycle.
//  - No stalls and no back-pressure: one write per cycle is always accepted.
//  - Latency: write to architectural state is 1 edge; write to read data is 0 cycles via bypass.
// TESTING
//  1. Reset: rst_n=0 mid-cycle with no clock edge
//     -> rsData=rtData=0 and wrCount=0 immediately.
//  2. Mux priority: ALU=5, dataMem=7, adder=9
//     -> memToReg=0,svpc=0 gives wbData=5; memToReg=1 gives 7; svpc=1 with memToReg=1 gives 9.
//  3. Write then read: regWrt=1, rd=12, ALU=32'hDEADBEEF, one edge; then regWrt=0, rs=12
//     -> rsData=32'hDEADBEEF and wrCount=1.
//  4. Bypass: regWrt=1, rd=rs=rt=40, dataMem=32'h1234, memToReg=1, all before the edge
//     -> rsData=rtData=32'h1234 in the same cycle.
//  5. Reset collision: regWrt=1, rd=3, rst_n pulsed low across the edge
//     -> regs[3]=0 and wrCount=0.
//  6. ZERO_REG=1: write 32'hFF to rd=0 -> rsData(rs=0)=0 and wrCount=1.
//     CNT_W=4: 16 writes -> wrCount wraps to 0.

Source files
------------

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile : writeback mux, 2**ADDR_W x DATA_W register file, bypassed reads
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memToReg,
  input  logic [DATA_W-1:0] dataMem,
  input  logic [DATA_W-1:0] ALU,
  input  logic              regWrt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] adder,
  input  logic              svpc,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] rsData,
  output logic [DATA_W-1:0] rtData,
  output logic [DATA_W-1:0] wbData,
  output logic [CNT_W-1:0]  wrCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              bypass_rs;
  logic              bypass_rt;

  // svpc has priority over memToReg
  assign wbData = svpc ? adder : (memToReg ? dataMem : ALU);

  // Each register owns its storage; a hardwired zero register has none.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
        assign regs[i] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            q <= '0;
          end else if (regWrt && (rd == ADDR_W'(i))) begin
            q <= wbData;
          end
        end
        assign regs[i] = q;
      end
    end
  endgenerate

  // Counts every accepted write, including ones discarded by a zero register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrCount <= '0;
    end else if (regWrt) begin
      wrCount <= wrCount + CNT_W'(1);
    end
  end

  assign bypass_rs = regWrt && (rd == rs) && !((ZERO_REG != 0) && (rs == '0));
  assign bypass_rt = regWrt && (rd == rt) && !((ZERO_REG != 0) && (rt == '0));

  always_comb begin
    rsData = regs[rs];
    rtData = regs[rt];
    if (bypass_rs) rsData = wbData;
    if (bypass_rt) rtData = wbData;
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile : directed vector bench for wb_regfile (default and zero-reg/4-bit counter builds)
// Revision      : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_regfile;

  logic        clk;
  logic        rst_n;

  logic        memToReg, regWrt, svpc;
  logic [31:0] dataMem, ALU, adder;
  logic [5:0]  rd, rs, rt;
  logic [31:0] rsData, rtData, wbData, wrCount;

  logic        z_memToReg, z_regWrt, z_svpc;
  logic [31:0] z_dataMem, z_ALU, z_adder;
  logic [5:0]  z_rd, z_rs, z_rt;
  logic [31:0] z_rsData, z_rtData, z_wbData;
  logic [3:0]  z_wrCount;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .memToReg(memToReg), .dataMem(dataMem), .ALU(ALU),
    .regWrt(regWrt), .rd(rd), .adder(adder), .svpc(svpc), .rs(rs), .rt(rt),
    .rsData(rsData), .rtData(rtData), .wbData(wbData), .wrCount(wrCount)
  );

  wb_regfile #(.ZERO_REG(1), .CNT_W(4)) dut_z (
    .clk(clk), .rst_n(rst_n), .memToReg(z_memToReg), .dataMem(z_dataMem), .ALU(z_ALU),
    .regWrt(z_regWrt), .rd(z_rd), .adder(z_adder), .svpc(z_svpc), .rs(z_rs), .rt(z_rt),
    .rsData(z_rsData), .rtData(z_rtData), .wbData(z_wbData), .wrCount(z_wrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        wr, m2r, sv;
    logic [5:0]  rd, rs, rt;
    logic [31:0] alu, mem, add;
    logic [31:0] e_wb, e_rs, e_rt, e_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic wr, m2r, sv,
                              input logic [5:0] d, s, t,
                              input logic [31:0] a, m, p, ewb, ers, ert, ecnt);
    vec_t v;
    v.name = n; v.wr = wr; v.m2r = m2r; v.sv = sv;
    v.rd = d; v.rs = s; v.rt = t; v.alu = a; v.mem = m; v.add = p;
    v.e_wb = ewb; v.e_rs = ers; v.e_rt = ert; v.e_cnt = ecnt;
    return v;
  endfunction

  initial begin
    // Expected read data and count are the values seen before the edge that commits the vector.
    vecs[0]  = mk("mux_alu",      0,0,0,  0, 0, 1, 32'd5, 32'd7, 32'd9, 32'd5, 0, 0, 0);
    vecs[1]  = mk("mux_mem",      0,1,0,  0, 0, 1, 32'd5, 32'd7, 32'd9, 32'd7, 0, 0, 0);
    vecs[2]  = mk("mux_svpc",     0,1,1,  0, 0, 1, 32'd5, 32'd7, 32'd9, 32'd9, 0, 0, 0);
    vecs[3]  = mk("wr12",         1,0,0, 12, 5, 6, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    vecs[4]  = mk("rd12",         0,0,0, 12,12,12, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    vecs[5]  = mk("bypass40",     1,1,0, 40,40,40, 0, 32'h1234, 0, 32'h1234, 32'h1234, 32'h1234, 1);
    vecs[6]  = mk("wr7_svpc",     1,0,1,  7,40,12, 0, 0, 32'hA5A50007, 32'hA5A50007, 32'h1234, 32'hDEADBEEF, 2);
    vecs[7]  = mk("wr0_ordinary", 1,0,0,  0, 0, 7, 32'h11, 0, 0, 32'h11, 32'h11, 32'hA5A50007, 3);
    vecs[8]  = mk("rd0_nowr",     0,0,0,  0, 0,63, 32'h22, 0, 0, 32'h22, 32'h11, 0, 4);
    vecs[9]  = mk("wr63_ones",    1,0,0, 63,63,40, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 4);
    vecs[10] = mk("overwrite12",  1,0,0, 12,12, 5, 32'h55, 0, 0, 32'h55, 32'h55, 0, 5);
    vecs[11] = mk("rd_after_ow",  0,0,0, 12,12,63, 0, 0, 0, 0, 32'h55, 32'hFFFFFFFF, 6);

    rst_n = 1'b1;
    {memToReg, regWrt, svpc, dataMem, ALU, adder, rd, rs, rt} = '0;
    rt = 6'd1;
    {z_memToReg, z_regWrt, z_svpc, z_dataMem, z_ALU, z_adder, z_rd, z_rs, z_rt} = '0;

    // Asynchronous reset with no clock edge in between
    #3 rst_n = 1'b0;
    #1;
    check("reset_rsData", rsData, 0);
    check("reset_rtData", rtData, 0);
    check("reset_wrCount", wrCount, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      regWrt = vecs[i].wr; memToReg = vecs[i].m2r; svpc = vecs[i].sv;
      rd = vecs[i].rd; rs = vecs[i].rs; rt = vecs[i].rt;
      ALU = vecs[i].alu; dataMem = vecs[i].mem; adder = vecs[i].add;
      #1;
      check({vecs[i].name, "_wbData"},  wbData,  vecs[i].e_wb);
      check({vecs[i].name, "_rsData"},  rsData,  vecs[i].e_rs);
      check({vecs[i].name, "_rtData"},  rtData,  vecs[i].e_rt);
      check({vecs[i].name, "_wrCount"}, wrCount, vecs[i].e_cnt);
    end

    // Reset held across a write edge: write discarded, bypass still visible meanwhile
    @(negedge clk);
    regWrt = 1'b1; memToReg = 1'b0; svpc = 1'b0; rd = 6'd3; ALU = 32'h77; rs = 6'd3; rt = 6'd12;
    rst_n = 1'b0;
    #1;
    check("rstcol_bypass_rs", rsData, 32'h77);
    check("rstcol_rt_cleared", rtData, 0);
    check("rstcol_wrCount", wrCount, 0);
    @(negedge clk);
    regWrt = 1'b0; rst_n = 1'b1;
    #1;
    check("rstcol_reg3", rsData, 0);
    check("rstcol_wrCount_after", wrCount, 0);

    // First edge after reset release writes normally
    @(negedge clk);
    regWrt = 1'b1; rd = 6'd3; ALU = 32'h99; rs = 6'd12;
    @(negedge clk);
    regWrt = 1'b0; rs = 6'd3;
    #1;
    check("postrst_reg3", rsData, 32'h99);
    check("postrst_wrCount", wrCount, 1);

    // Zero-register build: write to r0 is dropped but counted, bypass suppressed
    @(negedge clk);
    z_regWrt = 1'b1; z_rd = 6'd0; z_ALU = 32'hFF; z_rs = 6'd0; z_rt = 6'd0;
    #1;
    check("z_wbData", z_wbData, 32'hFF);
    check("z_bypass_rs0", z_rsData, 0);
    check("z_bypass_rt0", z_rtData, 0);
    @(negedge clk);
    z_regWrt = 1'b0;
    #1;
    check("z_r0_after", z_rsData, 0);
    check("z_wrCount1", {28'd0, z_wrCount}, 1);

    // Fifteen more writes wrap the 4-bit counter back to 0
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      z_regWrt = 1'b1; z_rd = 6'(k); z_ALU = 32'(k * 3);
      if (k == 15) begin
        #1;
        check("z_wrCount15", {28'd0, z_wrCount}, 15);
      end
    end
    @(negedge clk);
    z_regWrt = 1'b0; z_rs = 6'd5; z_rt = 6'd15;
    #1;
    check("z_wrap", {28'd0, z_wrCount}, 0);
    check("z_r5", z_rsData, 32'd15);
    check("z_r15", z_rtData, 32'd45);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
